// File: rtl/ac_drain_unit.sv
// ac_drain_unit: LANES parallel signed accumulators with a snapshot buffer that is
// drained one lane per accepted beat over a valid/ready stream.
//
// Optional feature macro: AC_SATURATE_EN
//   defined   -> lane sums clamp to the signed ACC_WIDTH range; any clamp sets ac_err
//   undefined -> lane sums wrap modulo 2^ACC_WIDTH; overflow never sets ac_err
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   w_data         LANES signed weights, lane i at [i*W_WIDTH +: W_WIDTH]
//   w_valid        w_data/spk_in qualifier
//   spk_in         presynaptic spike; weights accumulate only when w_valid & spk_in
//   cntrl_ac_reset clears the accumulators (after any same-cycle snapshot)
//   cntrl_ac_oen   snapshots the accumulators and starts the drain (IDLE only)
//   ac_out         drained lane value (signed), 0 when not valid
//   ac_out_lane    lane index of ac_out
//   ac_out_valid   beat valid
//   ac_out_ready   consumer accepts the beat
//   ac_out_last    beat carries lane LANES-1
//   ac_busy        drain in progress
//   ac_err         sticky: oen during a drain, or saturation clamp
module ac_drain_unit #(
  parameter int unsigned LANES     = 8,
  parameter int unsigned W_WIDTH   = 8,
  parameter int unsigned ACC_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [LANES*W_WIDTH-1:0]   w_data,
  input  logic                       w_valid,
  input  logic                       spk_in,
  input  logic                       cntrl_ac_reset,
  input  logic                       cntrl_ac_oen,
  output logic [ACC_WIDTH-1:0]       ac_out,
  output logic [$clog2(LANES)-1:0]   ac_out_lane,
  output logic                       ac_out_valid,
  input  logic                       ac_out_ready,
  output logic                       ac_out_last,
  output logic                       ac_busy,
  output logic                       ac_err
);

  localparam int unsigned LW = $clog2(LANES);
  localparam int unsigned SW = ACC_WIDTH + 1;
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

`ifdef AC_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t                       state_q, state_d;
  logic signed [ACC_WIDTH-1:0]  acc_q  [LANES];
  logic signed [ACC_WIDTH-1:0]  acc_d  [LANES];
  logic signed [ACC_WIDTH-1:0]  snap_q [LANES];
  logic signed [ACC_WIDTH-1:0]  snap_d [LANES];
  logic signed [ACC_WIDTH-1:0]  sum_c  [LANES];
  logic signed [SW-1:0]         wide_c [LANES];
  logic                         clamp_c;
  logic                         hit_c;
  logic [ACC_WIDTH-1:0]         out_d;
  logic [LW-1:0]                lane_d;
  logic                         valid_d, last_d, busy_d, err_d;

  assign hit_c = w_valid & spk_in;

  // Per-lane sum at ACC_WIDTH+1 bits, then clamp or wrap back to ACC_WIDTH.
  always_comb begin
    clamp_c = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      wide_c[i] = SW'(acc_q[i]) + SW'($signed(w_data[i*W_WIDTH +: W_WIDTH]));
      if (SAT_EN && (wide_c[i][SW-1] ^ wide_c[i][SW-2])) begin
        clamp_c  = 1'b1;
        sum_c[i] = wide_c[i][SW-1] ? ACC_MIN : ACC_MAX;
      end else begin
        sum_c[i] = wide_c[i][ACC_WIDTH-1:0];
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    snap_d  = snap_q;
    out_d   = ac_out;
    lane_d  = ac_out_lane;
    valid_d = ac_out_valid;
    last_d  = ac_out_last;
    err_d   = ac_err;

    if (hit_c) begin
      acc_d = sum_c;
      if (clamp_c) err_d = 1'b1;
    end
    // Clear wins over the same-cycle contribution; the snapshot below still sees it.
    if (cntrl_ac_reset) begin
      for (int i = 0; i < LANES; i++) acc_d[i] = '0;
    end

    case (state_q)
      IDLE: begin
        if (cntrl_ac_oen) begin
          snap_d  = hit_c ? sum_c : acc_q;
          state_d = DRAIN;
          valid_d = 1'b1;
          lane_d  = '0;
          last_d  = (LANES == 1);
          out_d   = hit_c ? sum_c[0] : acc_q[0];
        end
      end
      DRAIN: begin
        if (cntrl_ac_oen) err_d = 1'b1;
        if (ac_out_ready) begin
          if (ac_out_last) begin
            state_d = IDLE;
            valid_d = 1'b0;
            out_d   = '0;
            lane_d  = '0;
            last_d  = 1'b0;
          end else begin
            lane_d = ac_out_lane + LW'(1);
            out_d  = snap_q[lane_d];
            last_d = (lane_d == LW'(LANES - 1));
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == DRAIN);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      for (int i = 0; i < LANES; i++) begin
        acc_q[i]  <= '0;
        snap_q[i] <= '0;
      end
      ac_out       <= '0;
      ac_out_lane  <= '0;
      ac_out_valid <= 1'b0;
      ac_out_last  <= 1'b0;
      ac_busy      <= 1'b0;
      ac_err       <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      snap_q       <= snap_d;
      ac_out       <= out_d;
      ac_out_lane  <= lane_d;
      ac_out_valid <= valid_d;
      ac_out_last  <= last_d;
      ac_busy      <= busy_d;
      ac_err       <= err_d;
    end
  end

endmodule

// File: tb/tb_ac_drain_unit.sv
// tb_ac_drain_unit: directed scenarios plus randomized traffic for ac_drain_unit,
// checked every cycle against a queue-based behavioural model.
module tb_ac_drain_unit;

  localparam int LANES     = 8;
  localparam int W_WIDTH   = 8;
  localparam int ACC_WIDTH = 16;

  logic                      clk;
  logic                      reset;
  logic [LANES*W_WIDTH-1:0]  w_data;
  logic                      w_valid;
  logic                      spk_in;
  logic                      cntrl_ac_reset;
  logic                      cntrl_ac_oen;
  logic [ACC_WIDTH-1:0]      ac_out;
  logic [$clog2(LANES)-1:0]  ac_out_lane;
  logic                      ac_out_valid;
  logic                      ac_out_ready;
  logic                      ac_out_last;
  logic                      ac_busy;
  logic                      ac_err;

  int errors = 0;
  int checks = 0;

  ac_drain_unit #(.LANES(LANES), .W_WIDTH(W_WIDTH), .ACC_WIDTH(ACC_WIDTH)) dut (
    .clk(clk), .reset(reset), .w_data(w_data), .w_valid(w_valid), .spk_in(spk_in),
    .cntrl_ac_reset(cntrl_ac_reset), .cntrl_ac_oen(cntrl_ac_oen),
    .ac_out(ac_out), .ac_out_lane(ac_out_lane), .ac_out_valid(ac_out_valid),
    .ac_out_ready(ac_out_ready), .ac_out_last(ac_out_last), .ac_busy(ac_busy),
    .ac_err(ac_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int acc_m [LANES];
  int nxt_m [LANES];
  int qv [$];        // pending beats; lane index is LANES - qv.size()
  bit err_m;

  function automatic int lane_w(input int i);
    logic [W_WIDTH-1:0] raw;
    raw = w_data[i*W_WIDTH +: W_WIDTH];
    return int'($signed(raw));
  endfunction

  function automatic int add_acc(input int a, input int w, output bit clamp);
    longint s, hi, lo, m;
    m  = longint'(1) << ACC_WIDTH;
    hi = (longint'(1) << (ACC_WIDTH - 1)) - 1;
    lo = -hi - 1;
    s  = longint'(a) + longint'(w);
    clamp = 1'b0;
`ifdef AC_SATURATE_EN
    if (s > hi) begin s = hi; clamp = 1'b1; end
    else if (s < lo) begin s = lo; clamp = 1'b1; end
`else
    s = s & (m - 1);
    if (s > hi) s = s - m;
`endif
    return int'(s);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LANES; i++) acc_m[i] = 0;
      qv.delete();
      err_m = 1'b0;
    end else begin
      bit c;
      for (int i = 0; i < LANES; i++) begin
        nxt_m[i] = acc_m[i];
        if (w_valid && spk_in) begin
          nxt_m[i] = add_acc(acc_m[i], lane_w(i), c);
          if (c) err_m = 1'b1;
        end
      end
      if (qv.size() != 0) begin
        if (cntrl_ac_oen) err_m = 1'b1;
        if (ac_out_ready) void'(qv.pop_front());
      end else if (cntrl_ac_oen) begin
        for (int i = 0; i < LANES; i++) qv.push_back(nxt_m[i]);
      end
      for (int i = 0; i < LANES; i++) acc_m[i] = cntrl_ac_reset ? 0 : nxt_m[i];
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (qv.size() != 0) begin
      check("valid", ac_out_valid, 1);
      check("out", $signed(ac_out), qv[0]);
      check("lane", ac_out_lane, LANES - qv.size());
      check("last", ac_out_last, (qv.size() == 1) ? 1 : 0);
      check("busy", ac_busy, 1);
    end else begin
      check("valid_idle", ac_out_valid, 0);
      check("out_idle", $signed(ac_out), 0);
      check("lane_idle", ac_out_lane, 0);
      check("last_idle", ac_out_last, 0);
      check("busy_idle", ac_busy, 0);
    end
    check("err", ac_err, err_m);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    w_data = '0; w_valid = 0; spk_in = 0;
    cntrl_ac_reset = 0; cntrl_ac_oen = 0; ac_out_ready = 0;
  endtask

  task automatic set_lane0(input int w);
    w_data = '0;
    w_data[W_WIDTH-1:0] = W_WIDTH'(w);
  endtask

  task automatic start_drain();
    cntrl_ac_oen = 1; tick(); cntrl_ac_oen = 0;
  endtask

  task automatic drain_all();
    ac_out_ready = 1;
    for (int k = 0; k < LANES; k++) tick();
    ac_out_ready = 0;
  endtask

  initial begin
    reset = 0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", ac_out_valid, 0);
    check("rst_busy", ac_busy, 0);
    check("rst_err", ac_err, 0);
    check("rst_out", ac_out, 0);
    reset = 1;
    tick();

    // Three spikes of w=5, one non-spike w=7, then drain.
    set_lane0(5); w_valid = 1; spk_in = 1;
    repeat (3) tick();
    set_lane0(7); spk_in = 0; tick();
    idle_inputs();
    start_drain();
    check("a_first_valid", ac_out_valid, 1);
    check("a_first_busy", ac_busy, 1);
    ac_out_ready = 1;
    for (int k = 0; k < LANES; k++) begin
      check("a_lane", ac_out_lane, k);
      check("a_val", $signed(ac_out), (k == 0) ? 15 : 0);
      check("a_last", ac_out_last, (k == LANES - 1) ? 1 : 0);
      tick();
    end
    check("a_done_valid", ac_out_valid, 0);
    check("a_done_busy", ac_busy, 0);
    ac_out_ready = 0;

    // acc0=10, then oen + clear together with a w=2 spike.
    cntrl_ac_reset = 1; tick(); cntrl_ac_reset = 0;
    set_lane0(10); w_valid = 1; spk_in = 1; tick();
    set_lane0(2); cntrl_ac_oen = 1; cntrl_ac_reset = 1; tick();
    idle_inputs();
    check("b_snap_with_contrib", $signed(ac_out), 12);
    drain_all();
    start_drain();
    check("b_after_clear", $signed(ac_out), 0);
    check("b_after_clear_valid", ac_out_valid, 1);
    drain_all();

    // Backpressure: ready low for 5 cycles.
    for (int i = 0; i < LANES; i++) w_data[i*W_WIDTH +: W_WIDTH] = W_WIDTH'(i * 3 + 1);
    w_valid = 1; spk_in = 1; tick();
    idle_inputs();
    start_drain();
    for (int k = 0; k < 5; k++) begin
      check("c_hold_lane", ac_out_lane, 0);
      check("c_hold_out", $signed(ac_out), 1);
      check("c_hold_busy", ac_busy, 1);
      tick();
    end
    drain_all();
    check("c_idle_after_8", ac_busy, 0);

    // 300 accumulations of 127.
    cntrl_ac_reset = 1; tick(); cntrl_ac_reset = 0;
    set_lane0(127); w_valid = 1; spk_in = 1;
    repeat (300) tick();
    idle_inputs();
    start_drain();
`ifdef AC_SATURATE_EN
    check("d_sat_val", $signed(ac_out), 32767);
    check("d_sat_err", ac_err, 1);
`else
    check("d_wrap_val", $signed(ac_out), -27436);
    check("d_wrap_err", ac_err, 0);
`endif
    drain_all();

    // oen on beat 3 of a drain.
    start_drain();
    ac_out_ready = 1;
    repeat (3) tick();
    check("e_at_beat3", ac_out_lane, 3);
    cntrl_ac_oen = 1; tick(); cntrl_ac_oen = 0;
    check("e_err", ac_err, 1);
    repeat (4) tick();
    check("e_done", ac_out_valid, 0);
    ac_out_ready = 0;

    // Asynchronous reset mid-drain.
    for (int i = 0; i < LANES; i++) w_data[i*W_WIDTH +: W_WIDTH] = W_WIDTH'($urandom);
    w_valid = 1; spk_in = 1; tick();
    idle_inputs();
    start_drain();
    ac_out_ready = 1;
    repeat (2) tick();
    #2 reset = 0;
    #1;
    check("f_valid", ac_out_valid, 0);
    check("f_out", ac_out, 0);
    check("f_lane", ac_out_lane, 0);
    check("f_last", ac_out_last, 0);
    check("f_busy", ac_busy, 0);
    check("f_err", ac_err, 0);
    idle_inputs();
    @(posedge clk);
    #1 reset = 1;
    tick();
    check("f_release_valid", ac_out_valid, 0);
    check("f_release_busy", ac_busy, 0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < LANES; i++) w_data[i*W_WIDTH +: W_WIDTH] = W_WIDTH'($urandom);
      w_valid        = ($urandom_range(0, 1) == 1);
      spk_in         = ($urandom_range(0, 9) < 7);
      cntrl_ac_reset = ($urandom_range(0, 19) == 0);
      cntrl_ac_oen   = ($urandom_range(0, 9) == 0);
      ac_out_ready   = ($urandom_range(0, 9) < 6);
      tick();
    end
    idle_inputs();
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
